// File: rtl/draw_deck.sv
// draw_deck: three-stage pixel pipeline that addresses the deck sprite ROM
// and merges the returned sprite pixels into the passing VGA stream.
// The sprite position is latched once per frame, at pixel (0,0).
// Optional feature macro: DECK_TRANSPARENCY_EN. When it is defined, the key
// colour 12'h0F0 returned by the ROM lets the background show through.
module draw_deck #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 12,
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 96
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [10:0]           xpos,
    input  logic [10:0]           ypos,
    input  logic [10:0]           hcount_in,
    input  logic [10:0]           vcount_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  hblnk_in,
    input  logic                  vblnk_in,
    input  logic [11:0]           rgb_in,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [10:0]           hcount_out,
    output logic [10:0]           vcount_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  hblnk_out,
    output logic                  vblnk_out,
    output logic [11:0]           rgb_out
);

    // One pixel's worth of timing, colour and sprite-hit flag in flight.
    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
        logic        in_box;
    } pix_t;

    localparam logic [11:0] KEY_COLOUR = 12'h0F0;

    logic [10:0]           xpos_l;
    logic [10:0]           ypos_l;
    logic                  frame_start;
    logic [10:0]           x_eff;
    logic [10:0]           y_eff;
    logic [11:0]           x_lo;
    logic [11:0]           x_hi;
    logic [11:0]           y_lo;
    logic [11:0]           y_hi;
    logic                  in_box;
    logic [10:0]           dx;
    logic [10:0]           dy;
    logic [ADDR_WIDTH-1:0] addr_next;
    pix_t                  stage1;
    pix_t                  stage2;
    logic [11:0]           sprite_pix;

    // At frame start the freshly requested position is used directly, so a
    // sprite sitting on pixel (0,0) is hit with the new position. Bounds are
    // kept 12 bits wide so a sprite crossing 2047 is clipped, not wrapped.
    always_comb begin
        frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);
        x_eff       = frame_start ? xpos : xpos_l;
        y_eff       = frame_start ? ypos : ypos_l;
        x_lo        = {1'b0, x_eff};
        y_lo        = {1'b0, y_eff};
        x_hi        = x_lo + 12'(WIDTH);
        y_hi        = y_lo + 12'(HEIGHT);
        in_box      = ({1'b0, hcount_in} >= x_lo) && ({1'b0, hcount_in} < x_hi) &&
                      ({1'b0, vcount_in} >= y_lo) && ({1'b0, vcount_in} < y_hi);
        dx          = hcount_in - x_eff;
        dy          = vcount_in - y_eff;
        addr_next   = ADDR_WIDTH'(dy) * ADDR_WIDTH'(WIDTH) + ADDR_WIDTH'(dx);
    end

    // Latch the sprite position only at frame start to avoid tearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpos_l <= 11'd0;
            ypos_l <= 11'd0;
        end else if (frame_start) begin
            xpos_l <= xpos;
            ypos_l <= ypos;
        end
    end

    // Stage 1: issue the ROM address for in-box pixels and register the stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            stage1   <= '0;
        end else begin
            if (in_box) begin
                rom_addr <= addr_next;
            end
            stage1.hcount <= hcount_in;
            stage1.vcount <= vcount_in;
            stage1.hsync  <= hsync_in;
            stage1.vsync  <= vsync_in;
            stage1.hblnk  <= hblnk_in;
            stage1.vblnk  <= vblnk_in;
            stage1.rgb    <= rgb_in;
            stage1.in_box <= in_box;
        end
    end

    // Stage 2: hold the stream for the cycle in which the ROM answers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage2 <= '0;
        end else begin
            stage2 <= stage1;
        end
    end

    // Sprite pixel as seen by the mixer, with optional key-colour transparency.
    always_comb begin
        sprite_pix = 12'(rom_data);
`ifdef DECK_TRANSPARENCY_EN
        if (12'(rom_data) == KEY_COLOUR) begin
            sprite_pix = stage2.rgb;
        end
`endif
    end

    // Stage 3: blank, sprite or background selection into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out <= 11'd0;
            vcount_out <= 11'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= 12'h000;
        end else begin
            hcount_out <= stage2.hcount;
            vcount_out <= stage2.vcount;
            hsync_out  <= stage2.hsync;
            vsync_out  <= stage2.vsync;
            hblnk_out  <= stage2.hblnk;
            vblnk_out  <= stage2.vblnk;
            if (stage2.hblnk || stage2.vblnk) begin
                rgb_out <= 12'h000;
            end else if (stage2.in_box) begin
                rgb_out <= sprite_pix;
            end else begin
                rgb_out <= stage2.rgb;
            end
        end
    end

`ifndef DECK_TRANSPARENCY_EN
    // Key colour is only consulted when transparency is built in.
    logic unused_key;
    assign unused_key = ^KEY_COLOUR;
`endif

endmodule

// File: tb/tb_draw_deck.sv
// tb_draw_deck: directed-vector bench for draw_deck with a one-cycle ROM model.
// Honours DECK_TRANSPARENCY_EN to pick the key-colour expectation.
module tb_draw_deck;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] xpos = '0;
    logic [10:0] ypos = '0;
    logic [10:0] hcount_in = '0;
    logic [10:0] vcount_in = '0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        hblnk_in = 1'b0;
    logic        vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [12:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    logic        rom_force = 1'b0;
    int          errors = 0;
    int          checks = 0;

    draw_deck #(
        .ADDR_WIDTH(13),
        .DATA_WIDTH(12),
        .WIDTH(64),
        .HEIGHT(96)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .xpos(xpos),
        .ypos(ypos),
        .hcount_in(hcount_in),
        .vcount_in(vcount_in),
        .hsync_in(hsync_in),
        .vsync_in(vsync_in),
        .hblnk_in(hblnk_in),
        .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .hcount_out(hcount_out),
        .vcount_out(vcount_out),
        .hsync_out(hsync_out),
        .vsync_out(vsync_out),
        .hblnk_out(hblnk_out),
        .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    // Pixel clock, 10 time units per period.
    always #5 clk = ~clk;

    // Deck image contents: a fixed scramble of the address.
    function automatic logic [11:0] rom_content(input int addr);
        logic [11:0] a;
        a = 12'(addr);
        return a ^ 12'h5A5;
    endfunction

    // Synchronous ROM model, data valid one cycle after the address.
    always @(posedge clk) begin
        rom_data <= rom_force ? 12'h0F0 : rom_content(int'(rom_addr));
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic applyStimulus(input int h, input int v, input logic hs, input logic vs,
                                 input logic hb, input logic vb, input logic [11:0] rgb);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = hs;
        vsync_in  = vs;
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
        @(posedge clk);
        #1;
    endtask

    task automatic filler();
        applyStimulus(1500, 1500, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
    endtask

    initial begin
        logic [11:0] exp_rgb;
        int          src;

        // Reset state
        #12;
        checkOutput("reset_hcount", 32'(hcount_out), 0);
        checkOutput("reset_rgb", 32'(rgb_out), 0);
        checkOutput("reset_rom_addr", 32'(rom_addr), 0);
        rst_n = 1'b1;
        #5;

        // Frame start latches (100,50)
        xpos = 11'd100;
        ypos = 11'd50;
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
        checkOutput("frame0_rom_addr_hold", 32'(rom_addr), 0);
        xpos = 11'd300;

        // Bottom-right pixel of the sprite
        applyStimulus(163, 145, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111);
        checkOutput("addr_163_145", 32'(rom_addr), 6143);
        filler();
        filler();
        checkOutput("rgb_163_145", 32'(rgb_out), 32'(rom_content(6143)));
        checkOutput("hcount_163", 32'(hcount_out), 163);
        checkOutput("vcount_145", 32'(vcount_out), 145);

        // Just right of the sprite: address holds, background passes
        applyStimulus(164, 50, 1'b1, 1'b0, 1'b0, 1'b0, 12'hDEF);
        checkOutput("addr_hold_164", 32'(rom_addr), 6143);
        filler();
        filler();
        checkOutput("rgb_bg_164", 32'(rgb_out), 32'h0DEF);
        checkOutput("hsync_out_164", 32'(hsync_out), 1);

        // In-box pixel under horizontal blanking
        applyStimulus(120, 60, 1'b0, 1'b0, 1'b1, 1'b0, 12'hFFF);
        checkOutput("addr_120_60", 32'(rom_addr), 660);
        filler();
        filler();
        checkOutput("rgb_blank", 32'(rgb_out), 0);
        checkOutput("hblnk_out", 32'(hblnk_out), 1);

        // Mid-frame move has no effect yet
        applyStimulus(310, 60, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456);
        checkOutput("addr_nomove", 32'(rom_addr), 660);
        filler();
        filler();
        checkOutput("rgb_nomove", 32'(rgb_out), 32'h0456);

        // Next frame picks up (300,50)
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        applyStimulus(310, 60, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456);
        checkOutput("addr_moved", 32'(rom_addr), 650);
        filler();
        filler();
        checkOutput("rgb_moved", 32'(rgb_out), 32'(rom_content(650)));

        // Key colour from the ROM
        rom_force = 1'b1;
        applyStimulus(320, 70, 1'b0, 1'b0, 1'b0, 1'b0, 12'hABC);
        checkOutput("addr_key", 32'(rom_addr), 1300);
        filler();
        filler();
`ifdef DECK_TRANSPARENCY_EN
        exp_rgb = 12'hABC;
`else
        exp_rgb = 12'h0F0;
`endif
        checkOutput("rgb_key", 32'(rgb_out), 32'(exp_rgb));
        rom_force = 1'b0;

        // Right edge: sprite at x=780, row 5
        xpos = 11'd780;
        ypos = 11'd0;
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        filler();
        for (int h = 778; h <= 848; h++) begin
            applyStimulus(h, 5, 1'b0, 1'b0, 1'b0, 1'b0, 12'(h));
            if (h >= 780 && h <= 843) begin
                checkOutput("edge_addr", 32'(rom_addr), 32'(320 + h - 780));
            end else if (h == 844) begin
                checkOutput("edge_addr_hold", 32'(rom_addr), 383);
            end
            if (h >= 780) begin
                src = h - 2;
                if (src >= 780 && src <= 843) begin
                    exp_rgb = rom_content(320 + src - 780);
                end else begin
                    exp_rgb = 12'(src);
                end
                checkOutput("edge_rgb", 32'(rgb_out), 32'(exp_rgb));
            end
        end

        // Sprite past 2047 must not wrap its bounds
        xpos = 11'd2000;
        ypos = 11'd2000;
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        applyStimulus(2040, 2010, 1'b0, 1'b0, 1'b0, 1'b0, 12'h777);
        checkOutput("addr_far_2040", 32'(rom_addr), 680);
        applyStimulus(2047, 2047, 1'b0, 1'b0, 1'b0, 1'b0, 12'h777);
        checkOutput("addr_far_2047", 32'(rom_addr), 3055);

        // Frame start pixel inside the newly latched sprite
        xpos = 11'd0;
        ypos = 11'd0;
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h999);
        checkOutput("addr_origin", 32'(rom_addr), 0);
        filler();
        filler();
        checkOutput("rgb_origin", 32'(rgb_out), 32'(rom_content(0)));
        checkOutput("vsync_out_origin", 32'(vsync_out), 1);

        // Asynchronous reset mid-frame
        xpos = 11'd100;
        ypos = 11'd50;
        applyStimulus(200, 100, 1'b1, 1'b1, 1'b0, 1'b0, 12'h321);
        applyStimulus(30, 20, 1'b1, 1'b1, 1'b0, 1'b0, 12'h321);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_hcount", 32'(hcount_out), 0);
        checkOutput("async_hsync", 32'(hsync_out), 0);
        checkOutput("async_rom_addr", 32'(rom_addr), 0);
        #2;
        rst_n = 1'b1;
        applyStimulus(500, 7, 1'b0, 1'b0, 1'b0, 1'b0, 12'h246);
        checkOutput("refill_hcount", 32'(hcount_out), 0);
        applyStimulus(10, 10, 1'b0, 1'b0, 1'b0, 1'b0, 12'h135);
        checkOutput("reset_pos_addr", 32'(rom_addr), 650);
        filler();
        checkOutput("resume_hcount", 32'(hcount_out), 500);
        checkOutput("resume_rgb", 32'(rgb_out), 32'h0246);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
